fnd_scan_rx: RTL and testbench
==============================

// Module: fnd_scan_rx
// PURPOSE
//  Receive side of the multiplexed 6-digit FND bus produced by the display driver (seg[6:0], dp, enb[5:0]).
//  Samples the bus and tracks the digit scan, then rebuilds the six segment codes and converts each back to a BCD digit.
//  Used as an on-chip loopback monitor and as a bench checker for clock/display tops.
// PARAMETERS
//  SETTLE_CYC   4       clk cycles a bus value must hold unchanged before it is accepted
//  TIMEOUT_CYC  65536   clk cycles with no accepted digit before the lock is dropped
// PORTS
//  clk            in   1   system clock (50 MHz)
//  rst_n          in   1   asynchronous, active-low reset
//  i_seg          in   7   segment bus {a..g}, active-high
//  i_seg_dp       in   1   decimal point for the active digit
//  i_seg_enb      in   6   digit enables, active-low one-hot; bit k selects digit k
//  o_seg_raw      out  42  captured codes; digit k at [7k+6:7k]
//  o_digits       out  24  decoded digits; digit k at [4k+3:4k]
//  o_dp           out  6   captured dp per digit
//  o_frame_valid  out  1   1-cycle pulse when a complete frame is published
//  o_locked       out  1   high while scan sequence is being tracked correctly
//  o_err          out  1   1-cycle pulse on illegal enable, out-of-order digit or unknown code
//  o_timeout      out  1   1-cycle pulse when TIMEOUT_CYC expires
// BEHAVIOUR
//  Reset: all outputs 0, state HUNT, idx=0, counters 0, last-accepted enb=6'b111111.
//  Input path: 2-FF synchronizer on all 14 input bits. Settle counter clears on any bit change.
//   When the counter reaches SETTLE_CYC-1 and the sampled enb differs from the last accepted enb,
//   one accept event fires and the sample is latched. A held value gives exactly one event.
//  Enb classification: 6'b111111 = blank. On blank, last-accepted is updated and nothing else.
//   Exactly one 0 bit = digit k. Any other pattern = illegal.
//  Code decode: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 73->9, 00->4'hA (blank).
//   Any other code -> 4'hE, and o_err pulses. The capture still proceeds.
//  FSM HUNT: on a digit-0 event, store to shadow slot 0, idx=1, go CAPT. Other events are ignored.
//  FSM CAPT, event for digit idx: store to shadow slot idx, idx++.
//   If idx was 5: copy shadow to o_seg_raw/o_digits/o_dp, pulse o_frame_valid, set o_locked, idx=0.
//  FSM CAPT, digit-0 event with idx!=0: pulse o_err, restart the frame (slot 0, idx=1).
//  FSM CAPT, other out-of-order digit or illegal enb: pulse o_err, clear o_locked, go HUNT, idx=0.
//  Timeout counter: clears on every accept event and counts otherwise.
//   At TIMEOUT_CYC-1: pulse o_timeout, clear o_locked, go HUNT. The counter saturates until the next event.
//  Published outputs hold their last frame until the next complete frame. HUNT does not clear them.
//  Latency: last digit settles -> o_frame_valid = 2 (sync) + SETTLE_CYC + 1 clk.
//  Simultaneous error and timeout in one cycle: both pulse; the state goes to HUNT.
//  rst_n mid-frame: shadow is discarded; outputs return to reset values immediately (async).
// STRUCTURE
//  Shared package/header: FND code constants (SEG_0..SEG_9, SEG_BLANK), DIGIT_BLANK=4'hA, DIGIT_BAD=4'hE.
//  Shared package/header: FSM state encodings HUNT/CAPT.
//  Sub-module fnd_enc_rev: combinational 7-bit code -> {bad, 4-bit digit}. It is the inverse of the FND decoder.
//  Top level holds the synchronizer, settle counter, timeout counter, FSM and shadow/output registers.
// TESTING
//  1 Drive enb 111110..011111 with codes for 1,2,3,4,5,6, each held 20 clk, SETTLE_CYC=4.
//    Expect: o_frame_valid once; o_digits=24'h654321; o_locked=1.
//  2 Glitch enb for 2 clk mid-digit, then restore.
//    Expect: no accept event and no o_err; frame still completes with correct digits.
//  3 Scan order 0,1,3 (skip 2).
//    Expect: o_err pulse at digit 3; o_locked=0; next full 0..5 scan publishes a frame.
//  4 Send code 7'h01 on digit 4 within an otherwise valid frame.
//    Expect: o_err pulse; o_digits[19:16]=4'hE; frame still published.
//  5 Lock, then hold enb=111111 for TIMEOUT_CYC clk.
//    Expect: single o_timeout pulse; o_locked=0; o_digits unchanged.
//  6 Assert rst_n low after digit 3 of a frame.
//    Expect: all outputs 0 at once; after release, the next full scan gives a correct frame.

Source files
------------

// File: rtl/fnd_scan_rx_pkg.sv
// Shared FND segment codes, digit markers and receiver FSM states.
package fnd_scan_rx_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_BLANK = 4'hA;
  localparam logic [3:0] DIGIT_BAD   = 4'hE;

  localparam logic [5:0] ENB_BLANK = 6'b111111;

  typedef enum logic {
    HUNT = 1'b0,
    CAPT = 1'b1
  } state_t;

endpackage

// File: rtl/fnd_enc_rev.sv
// Inverse of the FND decoder: 7-bit segment code back to a BCD digit.
module fnd_enc_rev
  import fnd_scan_rx_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] digit,
  output logic       bad
);

  always_comb begin
    bad = 1'b0;
    unique case (code)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: digit = DIGIT_BLANK;
      default: begin
        digit = DIGIT_BAD;
        bad   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fnd_scan_rx.sv
// Receiver for the multiplexed 6-digit FND bus: tracks the scan and
// republishes each complete frame as raw codes, BCD digits and dp bits.
module fnd_scan_rx
  import fnd_scan_rx_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [41:0] o_seg_raw,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic        o_frame_valid,
  output logic        o_locked,
  output logic        o_err,
  output logic        o_timeout
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [13:0] SYNC_RST = {ENB_BLANK, 8'h00};

  logic [13:0]   sync1, sync2, samp_prev;
  logic [6:0]    s_seg;
  logic          s_dp;
  logic [5:0]    s_enb;
  logic [SW-1:0] settle;
  logic [TW-1:0] tcnt;
  logic [5:0]    last_enb;
  logic          stable, accept, hit;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d, k;
  logic          blank, legal, store, publish, err_d, lock_clr;
  logic [3:0]    dec_digit;
  logic          dec_bad;

  logic [41:0]   sh_seg;
  logic [23:0]   sh_dig;
  logic [5:0]    sh_dp;

  assign s_seg  = sync2[6:0];
  assign s_dp   = sync2[7];
  assign s_enb  = sync2[13:8];
  assign stable = (sync2 == samp_prev);
  assign accept = stable && (settle == SW'(SETTLE_CYC - 1)) && (s_enb != last_enb);
  assign hit    = !accept && (tcnt == TW'(TIMEOUT_CYC - 2));
  assign blank  = (s_enb == ENB_BLANK);
  assign legal  = $onehot(~s_enb);

  fnd_enc_rev u_rev (
    .code  (s_seg),
    .digit (dec_digit),
    .bad   (dec_bad)
  );

  // Sync chain resets to the idle bus so release from reset is not a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= SYNC_RST;
      sync2     <= SYNC_RST;
      samp_prev <= SYNC_RST;
      settle    <= '0;
      tcnt      <= '0;
      last_enb  <= ENB_BLANK;
    end else begin
      sync1     <= {i_seg_enb, i_seg_dp, i_seg};
      sync2     <= sync1;
      samp_prev <= sync2;
      if (!stable)                               settle <= '0;
      else if (settle != SW'(SETTLE_CYC - 1))    settle <= settle + 1'b1;
      if (accept)                                tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYC - 1))     tcnt <= tcnt + 1'b1;
      if (accept)                                last_enb <= s_enb;
    end
  end

  always_comb begin
    k = '0;
    for (int unsigned i = 0; i < 6; i++)
      if (!s_enb[i]) k = 3'(i);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    store    = 1'b0;
    publish  = 1'b0;
    err_d    = 1'b0;
    lock_clr = 1'b0;
    if (accept && !blank) begin
      if (state_q == HUNT) begin
        if (legal && k == 3'd0) begin
          store   = 1'b1;
          idx_d   = 3'd1;
          state_d = CAPT;
        end
      end else if (legal && k == idx_q) begin
        store = 1'b1;
        if (idx_q == 3'd5) begin
          publish = 1'b1;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else if (legal && k == 3'd0) begin
        err_d = 1'b1;
        store = 1'b1;
        idx_d = 3'd1;
      end else begin
        err_d    = 1'b1;
        lock_clr = 1'b1;
        state_d  = HUNT;
        idx_d    = 3'd0;
      end
    end
    if (store && dec_bad) err_d = 1'b1;
    if (hit) begin
      lock_clr = 1'b1;
      state_d  = HUNT;
      idx_d    = 3'd0;
    end
  end

  // Slot 5 is published straight from the current sample, not the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      idx_q         <= '0;
      sh_seg        <= '0;
      sh_dig        <= '0;
      sh_dp         <= '0;
      o_seg_raw     <= '0;
      o_digits      <= '0;
      o_dp          <= '0;
      o_frame_valid <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      o_frame_valid <= publish;
      o_err         <= err_d;
      o_timeout     <= hit;
      if (store) begin
        sh_seg[7*k +: 7] <= s_seg;
        sh_dig[4*k +: 4] <= dec_digit;
        sh_dp[k]         <= s_dp;
      end
      if (publish) begin
        o_seg_raw <= {s_seg, sh_seg[34:0]};
        o_digits  <= {dec_digit, sh_dig[19:0]};
        o_dp      <= {s_dp, sh_dp[4:0]};
        o_locked  <= 1'b1;
      end else if (lock_clr) begin
        o_locked  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_rx.sv
// Directed bench for fnd_scan_rx: drives scan sequences on the FND bus and
// checks published frames, lock, error and timeout behaviour.
module tb_fnd_scan_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h00;
  logic        seg_dp = 1'b0;
  logic [5:0]  seg_enb = 6'b111111;
  logic [41:0] seg_raw;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic        frame_valid, locked, err, timeout;

  int checks = 0;
  int failures = 0;
  int fv_cnt = 0, err_cnt = 0, to_cnt = 0;

  always #5 clk = ~clk;

  fnd_scan_rx #(.SETTLE_CYC(4), .TIMEOUT_CYC(65536)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_seg         (seg),
    .i_seg_dp      (seg_dp),
    .i_seg_enb     (seg_enb),
    .o_seg_raw     (seg_raw),
    .o_digits      (digits),
    .o_dp          (dp),
    .o_frame_valid (frame_valid),
    .o_locked      (locked),
    .o_err         (err),
    .o_timeout     (timeout)
  );

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (err)         err_cnt++;
    if (timeout)     to_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_digit(input int k, input logic [6:0] code, input int hold);
    seg     = code;
    seg_dp  = (k == 2);
    seg_enb = ~(6'd1 << k);
    tick(hold);
  endtask

  // codes packed with digit k at [7k+6:7k]; glitch_dig < 0 means no glitch
  task automatic send_frame(input logic [41:0] codes, input int glitch_dig);
    for (int k = 0; k < 6; k++) begin
      if (k == glitch_dig) begin
        send_digit(k, codes[7*k +: 7], 8);
        seg_enb = 6'b111111;
        tick(2);
        send_digit(k, codes[7*k +: 7], 10);
      end else begin
        send_digit(k, codes[7*k +: 7], 20);
      end
    end
  endtask

  int fv0, err0, to0, waited;
  logic [41:0] f1, f2, f3, f4, f6;

  initial begin
    f1 = {7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30};  // 6 5 4 3 2 1
    f2 = {7'h6D, 7'h30, 7'h7E, 7'h73, 7'h7F, 7'h70};  // 2 1 0 9 8 7
    f3 = {7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E};  // 5 4 3 2 1 0
    f4 = {7'h5B, 7'h01, 7'h5F, 7'h70, 7'h7F, 7'h73};  // 5 bad 6 7 8 9
    f6 = {7'h73, 7'h5B, 7'h30, 7'h33, 7'h30, 7'h79};  // 9 5 1 4 1 3

    tick(3);
    check("rst_raw", 64'(seg_raw), 64'h0);
    check("rst_digits", 64'(digits), 64'h0);
    check("rst_dp", 64'(dp), 64'h0);
    check("rst_flags", 64'({frame_valid, locked, err, timeout}), 64'h0);
    rst_n = 1'b1;
    tick(5);

    // 1: clean frame
    fv0 = fv_cnt; err0 = err_cnt;
    send_frame(f1, -1);
    check("t1_fv", 64'(fv_cnt - fv0), 64'd1);
    check("t1_err", 64'(err_cnt - err0), 64'd0);
    check("t1_digits", 64'(digits), 64'h654321);
    check("t1_raw", 64'(seg_raw), 64'(f1));
    check("t1_dp", 64'(dp), 64'b000100);
    check("t1_locked", 64'(locked), 64'd1);

    // 2: 2-clk blank glitch inside digit 2
    fv0 = fv_cnt; err0 = err_cnt;
    send_frame(f2, 2);
    check("t2_fv", 64'(fv_cnt - fv0), 64'd1);
    check("t2_err", 64'(err_cnt - err0), 64'd0);
    check("t2_digits", 64'(digits), 64'h210987);

    // 3: skip digit 2
    fv0 = fv_cnt; err0 = err_cnt;
    send_digit(0, 7'h7E, 20);
    send_digit(1, 7'h30, 20);
    send_digit(3, 7'h79, 20);
    check("t3_err", 64'(err_cnt - err0), 64'd1);
    check("t3_locked", 64'(locked), 64'd0);
    check("t3_hold", 64'(digits), 64'h210987);
    check("t3_nofv", 64'(fv_cnt - fv0), 64'd0);
    send_frame(f3, -1);
    check("t3_fv", 64'(fv_cnt - fv0), 64'd1);
    check("t3_digits", 64'(digits), 64'h543210);
    check("t3_relock", 64'(locked), 64'd1);

    // 4: unknown code on digit 4
    fv0 = fv_cnt; err0 = err_cnt;
    send_frame(f4, -1);
    check("t4_err", 64'(err_cnt - err0), 64'd1);
    check("t4_fv", 64'(fv_cnt - fv0), 64'd1);
    check("t4_digits", 64'(digits), 64'h5E6789);
    check("t4_raw", 64'(seg_raw), 64'(f4));

    // 5: timeout after lock
    to0 = to_cnt;
    seg = 7'h00;
    seg_enb = 6'b111111;
    waited = 0;
    while (to_cnt == to0 && waited < 70000) begin
      tick(1);
      waited++;
    end
    tick(100);
    check("t5_to", 64'(to_cnt - to0), 64'd1);
    check("t5_wait_lo", 64'(waited >= 65530), 64'd1);
    check("t5_wait_hi", 64'(waited <= 65550), 64'd1);
    check("t5_locked", 64'(locked), 64'd0);
    check("t5_digits", 64'(digits), 64'h5E6789);

    // 6: reset mid-frame
    send_digit(0, 7'h79, 20);
    send_digit(1, 7'h30, 20);
    send_digit(2, 7'h33, 20);
    send_digit(3, 7'h30, 20);
    rst_n = 1'b0;
    #1;
    check("t6_raw", 64'(seg_raw), 64'h0);
    check("t6_digits", 64'(digits), 64'h0);
    check("t6_dp", 64'(dp), 64'h0);
    check("t6_flags", 64'({frame_valid, locked, err, timeout}), 64'h0);
    seg_enb = 6'b111111;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    fv0 = fv_cnt; err0 = err_cnt;
    send_frame(f6, -1);
    check("t6_fv", 64'(fv_cnt - fv0), 64'd1);
    check("t6_err", 64'(err_cnt - err0), 64'd0);
    check("t6_digits", 64'(digits), 64'h951413);
    check("t6_locked", 64'(locked), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
